// File: rtl/line_decoder8_pulse.sv
// Registered 3-to-8 active-low line decoder with a fixed-width output pulse and valid/ready intake.
// Optional feature macro: DECODER_RETRIGGER_EN (accept codes during PULSE to extend or preempt).
module line_decoder8_pulse #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       iClk,
    input  logic       iRst_L,
    input  logic [2:0] iY_L,
    input  logic       iYex_L,
    input  logic       iYs,
    input  logic       iValid,
    output logic       oReady,
    output logic [7:0] oI_L,
    output logic       oBusy,
    output logic       oNone,
    output logic       oErr
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } stateT;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W - 1);

    stateT            state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic [7:0]       lineNxt;
    logic             noneNxt, errNxt;
    logic             accept, isActive, isNone, isErr;
    logic [7:0]       decoded;

`ifdef DECODER_RETRIGGER_EN
    assign oReady = (state == IDLE) || (state == PULSE);
`else
    assign oReady = (state == IDLE);
`endif
    assign oBusy    = (state != IDLE);
    assign accept   = iValid & oReady;
    assign isActive = ~iYex_L &  iYs;
    assign isNone   =  iYex_L & ~iYs;
    assign isErr    = ~iYex_L & ~iYs;
    // Active-low code: inverted iY_L is the line index.
    assign decoded  = ~(8'd1 << (~iY_L));

    always_ff @(posedge iClk or negedge iRst_L) begin
        if (!iRst_L) begin
            state <= IDLE;
            cnt   <= '0;
            oI_L  <= 8'hFF;
            oNone <= 1'b0;
            oErr  <= 1'b0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
            oI_L  <= lineNxt;
            oNone <= noneNxt;
            oErr  <= errNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        lineNxt  = oI_L;
        noneNxt  = accept & isNone;
        errNxt   = accept & isErr;
        case (state)
            IDLE: begin
                lineNxt = 8'hFF;
                if (accept && isActive) begin
                    lineNxt  = decoded;
                    cntNxt   = CNT_LOAD;
                    stateNxt = PULSE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    lineNxt  = 8'hFF;
                    stateNxt = GAP;
                end else begin
                    cntNxt = cnt - CNT_W'(1);
                end
`ifdef DECODER_RETRIGGER_EN
                // New active code overrides the countdown on the same edge.
                if (accept && isActive) begin
                    lineNxt  = decoded;
                    cntNxt   = CNT_LOAD;
                    stateNxt = PULSE;
                end
`endif
            end
            GAP: begin
                lineNxt  = 8'hFF;
                stateNxt = IDLE;
            end
            default: begin
                lineNxt  = 8'hFF;
                cntNxt   = '0;
                stateNxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_line_decoder8_pulse.sv
// Randomized bench for line_decoder8_pulse against a timestamp-based reference model.
module tb_line_decoder8_pulse;
    localparam int PW = 4;

    logic       iClk = 1'b0;
    logic       iRst_L;
    logic [2:0] iY_L;
    logic       iYex_L, iYs, iValid;
    logic       oReady, oBusy, oNone, oErr;
    logic [7:0] oI_L;

    int nChecks = 0;
    int nFail   = 0;

    // Model: edge counter, edge of the last accepted active code and its line.
    int cyc     = 0;
    int lastAcc = -1000;
    int lastLine = 0;
    bit mNone = 1'b0, mErr = 1'b0, mReady = 1'b1;

    line_decoder8_pulse #(.PULSE_W(PW), .CNT_W(8)) dut (
        .iClk(iClk), .iRst_L(iRst_L), .iY_L(iY_L), .iYex_L(iYex_L), .iYs(iYs),
        .iValid(iValid), .oReady(oReady), .oI_L(oI_L), .oBusy(oBusy),
        .oNone(oNone), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] expLines();
        int d = cyc - lastAcc;
        return (d >= 0 && d < PW) ? (8'hFF ^ 8'(1 << lastLine)) : 8'hFF;
    endfunction

    function automatic bit expBusy();
        int d = cyc - lastAcc;
        return d >= 0 && d <= PW;
    endfunction

    // One clock cycle: drive at negedge, predict the edge, check after it.
    task automatic doCycle(input bit v, input logic [2:0] y, input bit ex, input bit s);
        bit acc;
        iValid = v; iY_L = y; iYex_L = ex; iYs = s;
        #1;
        checkVal("ready", 8'(oReady), 8'(mReady));
        acc = v && mReady;
        @(posedge iClk);
        cyc++;
        mNone = acc && ex && !s;
        mErr  = acc && !ex && !s;
        if (acc && !ex && s) begin
            lastAcc  = cyc;
            lastLine = 7 - int'(y);
        end
        @(negedge iClk);
`ifdef DECODER_RETRIGGER_EN
        mReady = (cyc - lastAcc) != PW;
`else
        mReady = !expBusy();
`endif
        checkVal("lines", oI_L, expLines());
        checkVal("busy", 8'(oBusy), 8'(expBusy()));
        checkVal("none", 8'(oNone), 8'(mNone));
        checkVal("err", 8'(oErr), 8'(mErr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) doCycle(1'b0, 3'b000, 1'b1, 1'b1);
    endtask

    initial begin
        int lowReady, lowLine, r;
        iRst_L = 1'b1; iValid = 1'b0; iY_L = 3'b000; iYex_L = 1'b1; iYs = 1'b1;
        #1 iRst_L = 1'b0;
        #2;
        checkVal("rst_lines", oI_L, 8'hFF);
        checkVal("rst_busy", 8'(oBusy), 8'h00);
        checkVal("rst_none", 8'(oNone), 8'h00);
        checkVal("rst_err", 8'(oErr), 8'h00);
        checkVal("rst_ready", 8'(oReady), 8'h01);
        @(negedge iClk); @(negedge iClk);
        iRst_L = 1'b1;

        // First pulse on line 7: count ready-low and line-low cycles.
        lowReady = 0; lowLine = 0;
        doCycle(1'b1, 3'b000, 1'b0, 1'b1);
        if (!oReady) lowReady++;
        if (oI_L == 8'h7F) lowLine++;
        for (int i = 0; i < PW + 2; i++) begin
            doCycle(1'b0, 3'b000, 1'b1, 1'b1);
            if (!oReady) lowReady++;
            if (oI_L == 8'h7F) lowLine++;
        end
`ifdef DECODER_RETRIGGER_EN
        checkVal("ready_low_cycles", 8'(lowReady), 8'd1);
`else
        checkVal("ready_low_cycles", 8'(lowReady), 8'(PW + 1));
`endif
        checkVal("line_low_cycles", 8'(lowLine), 8'(PW));

        // Sweep every active code.
        for (int k = 0; k < 8; k++) begin
            doCycle(1'b1, 3'(k), 1'b0, 1'b1);
            checkVal("onehot", 8'($countones(~oI_L)), 8'd1);
            idle(PW + 1);
        end

        // No-request, illegal and disabled codes from IDLE.
        doCycle(1'b1, 3'b011, 1'b1, 1'b0); idle(1);
        doCycle(1'b1, 3'b011, 1'b0, 1'b0); idle(1);
        doCycle(1'b1, 3'b011, 1'b1, 1'b1); idle(1);

        // Valid held high across a pulse with alternating codes.
        for (int i = 0; i < 2 * (PW + 2) + 1; i++)
            doCycle(1'b1, (i % 2 == 0) ? 3'b101 : 3'b010, 1'b0, 1'b1);
        idle(PW + 2);

        // Retrigger scenario: line 3, line 3 again at +2, then line 6 mid-pulse.
        doCycle(1'b1, 3'b100, 1'b0, 1'b1);
        idle(1);
        doCycle(1'b1, 3'b100, 1'b0, 1'b1);
        idle(PW - 2);
        doCycle(1'b1, 3'b001, 1'b0, 1'b1);
        doCycle(1'b1, 3'b000, 1'b1, 1'b0);
        idle(PW + 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 7));
            doCycle($urandom_range(0, 3) != 0, 3'($urandom),
                    (r == 5 || r == 7), !(r == 5 || r == 6));
        end
        idle(PW + 2);

        // Asynchronous reset in the middle of a pulse.
        doCycle(1'b1, 3'b110, 1'b0, 1'b1);
        idle(1);
        iValid = 1'b0;
        #2 iRst_L = 1'b0;
        #1;
        checkVal("arst_lines", oI_L, 8'hFF);
        checkVal("arst_busy", 8'(oBusy), 8'h00);
        checkVal("arst_ready", 8'(oReady), 8'h01);
        @(negedge iClk);
        iRst_L = 1'b1;
        lastAcc = -1000; mNone = 1'b0; mErr = 1'b0; mReady = 1'b1;
        idle(2);
        doCycle(1'b1, 3'b111, 1'b0, 1'b1);
        idle(PW + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
